// File: rtl/mem_arbiter.sv
// Main-memory sequencer for the 16-bit CPU: arbitrates I-fill, D-fill and D write-through.
// Optional macro ARB_ROUND_ROBIN_EN alternates fill grants between I and D sides.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_miss_req,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    input  logic                         d_miss_req,
    input  logic [ADDR_W-1:0]            d_miss_addr,
    input  logic                         d_wr_req,
    input  logic [ADDR_W-1:0]            d_wr_addr,
    input  logic [DATA_W-1:0]            d_wr_data,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_rvalid,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         i_fill_we,
    output logic                         d_fill_we,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         busy
);

    localparam int WORD_W = $clog2(BLK_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(2 * BLK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFILL,
        S_DFILL,
        S_DWRITE,
        S_DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   rcv_cnt;
    logic               last_d;
    logic               pick_d_fill;
    logic               filling;
    logic               rx;
    logic               last_rx;

    // Fill arbitration between the two miss requesters (write-through is handled first in IDLE).
    always_comb begin
        pick_d_fill = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        pick_d_fill = d_miss_req && (!i_miss_req || !last_d);
`else
        pick_d_fill = d_miss_req;
`endif
    end

    assign filling = (state == S_IFILL) || (state == S_DFILL);
    assign rx      = mem_rvalid && filling;
    assign last_rx = rx && (rcv_cnt == CNT_W'(BLK_WORDS - 1));

    // Returning words go straight to the cache arrays; stale returns outside a fill are dropped.
    assign i_fill_we = mem_rvalid && (state == S_IFILL);
    assign d_fill_we = mem_rvalid && (state == S_DFILL);
    assign fill_data = rx ? mem_rdata : '0;
    assign fill_word = rx ? rcv_cnt[WORD_W-1:0] : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base      <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            last_d    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    issue_cnt <= '0;
                    rcv_cnt   <= '0;
                    if (d_wr_req) begin
                        state <= S_DWRITE;
                    end else if (pick_d_fill) begin
                        state  <= S_DFILL;
                        base   <= d_miss_addr & ~OFS_MASK;
                        last_d <= 1'b1;
                    end else if (i_miss_req) begin
                        state  <= S_IFILL;
                        base   <= i_miss_addr & ~OFS_MASK;
                        last_d <= 1'b0;
                    end
                end
                S_IFILL, S_DFILL: begin
                    // Issue side runs ahead of the return side by the memory latency.
                    if (issue_cnt < CNT_W'(BLK_WORDS)) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= base + ADDR_W'({issue_cnt, 1'b0});
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (rx) begin
                        rcv_cnt <= rcv_cnt + CNT_W'(1);
                    end
                    if (last_rx) begin
                        state <= S_DONE;
                        if (state == S_IFILL) begin
                            i_done <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                        end
                    end
                end
                S_DWRITE: begin
                    if (issue_cnt == '0) begin
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_wr_addr;
                        mem_wdata <= d_wr_data;
                        issue_cnt <= CNT_W'(1);
                    end else begin
                        state  <= S_DONE;
                        d_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
